// File: rtl/seq_shifter.sv
// seq_shifter: iterative SLL/SRL/SRA unit producing result plus last-bit-out carry.
// Define SEQ_SHIFTER_FAST_EN to shift up to 4 bits per cycle instead of 1.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;

    // One single-bit shift step, returned as {carry, result}; op 11 holds both.
    function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] r, input logic c, input logic [1:0] o);
        return (o == 2'b00) ? {r[WIDTH-1], r[WIDTH-2:0], 1'b0} :
               (o == 2'b01) ? {r[0], 1'b0, r[WIDTH-1:1]} :
               (o == 2'b10) ? {r[0], r[WIDTH-1], r[WIDTH-1:1]} : {c, r};
    endfunction

`ifdef SEQ_SHIFTER_FAST_EN
    logic [CNT_W-1:0] amt;
    logic [WIDTH:0]   acc;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
`ifdef SEQ_SHIFTER_FAST_EN
        amt = '0;
        acc = {carry_q, result_q};
`endif
        if (state_q == S_IDLE || state_q == S_DONE) begin
            state_d = S_IDLE;
            if (start) begin
                state_d  = S_SHIFT;
                op_d     = op;
                cnt_d    = (shamt >= WIDTH) ? CNT_MAX : shamt[CNT_W-1:0];
                result_d = operand;
                carry_d  = 1'b0;
            end
        end else if (state_q == S_SHIFT) begin
            if (cnt_q == '0) begin
                state_d = S_DONE;
            end else begin
`ifdef SEQ_SHIFTER_FAST_EN
                amt = (cnt_q > CNT_W'(4)) ? CNT_W'(4) : cnt_q;
                for (int i = 0; i < 4; i++)
                    if (CNT_W'(i) < amt) acc = step(acc[WIDTH-1:0], acc[WIDTH], op_q);
                {carry_d, result_d} = acc;
                cnt_d = cnt_q - amt;
`else
                {carry_d, result_d} = step(result_q, carry_q, op_q);
                cnt_d = cnt_q - 1'b1;
`endif
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign busy   = (state_q == S_SHIFT);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign carry  = carry_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: vector table, random model compare and reset/ignored-start sequences.
module tb_seq_shifter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand = '0;
    logic [31:0] shamt = '0;
    logic        busy, done, carry;
    logic [31:0] result;
    int total = 0;
    int bad = 0;

    seq_shifter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .operand(operand),
        .shamt(shamt), .busy(busy), .done(done), .result(result), .carry(carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] s;
        int          n;
        logic [31:0] r;
        logic        c;
    } vec_t;
    vec_t vt[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input int n);
`ifdef SEQ_SHIFTER_FAST_EN
        return (n + 3) / 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    // Shift via a 64-bit window: the bit just outside the result half is the last bit out.
    function automatic logic [32:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input int n);
        logic [63:0] w;
        if (o == 2'd0) begin
            w = {32'b0, a} << n;
            return {(n > 0) && w[32], w[31:0]};
        end
        w = (o == 2'd3) ? {a, 32'b0} : (o == 2'd1) ? ({a, 32'b0} >> n) : 64'($signed({a, 32'b0}) >>> n);
        return {(o != 2'd3) && (n > 0) && w[31], w[63:32]};
    endfunction

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] s,
                       output logic [31:0] r, output logic c, output int lat);
        @(negedge clk);
        op = o; operand = a; shamt = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; operand = $urandom; shamt = $urandom; op = 2'($urandom);
        check("busy_after_start", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        c = carry;
    endtask

    initial begin
        logic [31:0] r;
        logic        c;
        logic [32:0] m;
        int          lat, n, pulses;
        logic [31:0] s;
        logic [1:0]  o;
        vt[0]  = '{2'd0, 32'h00000001, 32'd4,          4,  32'h00000010, 1'b0};
        vt[1]  = '{2'd2, 32'h80000000, 32'd31,         31, 32'hFFFFFFFF, 1'b0};
        vt[2]  = '{2'd1, 32'h80000000, 32'd31,         31, 32'h00000001, 1'b0};
        vt[3]  = '{2'd1, 32'h80000001, 32'd1,          1,  32'h40000000, 1'b1};
        vt[4]  = '{2'd0, 32'hF0000000, 32'd2,          2,  32'hC0000000, 1'b1};
        vt[5]  = '{2'd0, 32'hFFFFFFFF, 32'd40,         32, 32'h00000000, 1'b1};
        vt[6]  = '{2'd0, 32'hFFFFFFFF, 32'd0,          0,  32'hFFFFFFFF, 1'b0};
        vt[7]  = '{2'd2, 32'h80000000, 32'd9,          9,  32'hFFC00000, 1'b0};
        vt[8]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF,   32, 32'hFFFFFFFF, 1'b1};
        vt[9]  = '{2'd1, 32'h12345678, 32'd32,         32, 32'h00000000, 1'b0};
        vt[10] = '{2'd3, 32'hDEADBEEF, 32'd5,          5,  32'hDEADBEEF, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_carry", {31'b0, carry}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run(vt[i].o, vt[i].a, vt[i].s, r, c, lat);
            check($sformatf("vec%0d_result", i), r, vt[i].r);
            check($sformatf("vec%0d_carry", i), {31'b0, c}, {31'b0, vt[i].c});
            check($sformatf("vec%0d_latency", i), lat, exp_lat(vt[i].n));
        end

        for (int i = 0; i < 200; i++) begin
            o = 2'($urandom);
            s = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
            n = (s > 32) ? 32 : int'(s);
            m = ref_shift(o, vt[0].a ^ 32'(i * 32'h9E3779B9), n);
            run(o, vt[0].a ^ 32'(i * 32'h9E3779B9), s, r, c, lat);
            check($sformatf("rnd%0d_result", i), r, m[31:0]);
            check($sformatf("rnd%0d_carry", i), {31'b0, c}, {31'b0, m[32]});
            check($sformatf("rnd%0d_latency", i), lat, exp_lat(n));
        end

        @(posedge clk);
        #1;
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("result_held", result, r);

        // Second start while busy must be ignored.
        @(negedge clk);
        op = 2'd0; operand = 32'h1; shamt = 32'd10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; operand = 32'hFFFF; shamt = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 3;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ign_latency", lat, exp_lat(10));
        check("ign_result", result, 32'h00000400);
        check("ign_carry", {31'b0, carry}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("ign_no_second_done", pulses, 0);
        check("ign_result_held", result, 32'h00000400);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        op = 2'd0; operand = 32'hFFFFFFFF; shamt = 32'd20; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_carry", {31'b0, carry}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        check("arst_no_done", pulses, 0);

        run(vt[3].o, vt[3].a, vt[3].s, r, c, lat);
        check("post_rst_result", r, vt[3].r);
        check("post_rst_carry", {31'b0, c}, {31'b0, vt[3].c});
        check("post_rst_latency", lat, exp_lat(vt[3].n));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
